// File: rtl/monkey_collision_detect.sv
`default_nettype none
// ============================================================================
// Module      : monkey_collision_detect
// Description : Per-frame collision detector for the monkey sprite. Counts
//               wall/monkey overlap pixels in each edge band of the sprite,
//               notes any ladder overlap, and on every start-of-frame turns
//               the finished frame into a one-cycle report pulse plus a held
//               edge code.
// Revision    : 1.0 - initial release
// ============================================================================
module monkey_collision_detect #(
   parameter int OBJECT_WIDTH  = 32,
   parameter int OBJECT_HEIGHT = 32,
   parameter int EDGE_W        = 4,
   parameter int HIT_MIN       = 2
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic [10:0] topLeftX,
   input  logic [10:0] topLeftY,
   input  logic        monkeyDrawingRequest,
   input  logic        wallDrawingRequest,
   input  logic        ladderDrawingRequest,
   output logic        wallCollision,
   output logic        ladderCollision,
   output logic [3:0]  HitEdgeCode
);

   localparam logic signed [11:0] OBJ_W    = 12'(OBJECT_WIDTH);
   localparam logic signed [11:0] OBJ_H    = 12'(OBJECT_HEIGHT);
   localparam logic signed [11:0] EDGE_S   = 12'(EDGE_W);
   localparam logic        [7:0]  HIT_THR  = 8'(HIT_MIN);
   localparam logic        [7:0]  CNT_MAX  = 8'hFF;

   typedef enum logic [0:0] {
      ACCUM  = 1'b0,
      REPORT = 1'b1
   } state_t;

   state_t            state;
   state_t            next_state;

   logic signed [11:0] off_x;
   logic signed [11:0] off_y;
   logic               in_sprite;
   logic [3:0]         band;          // [3] left, [2] top, [1] right, [0] bottom
   logic [3:0]         edge_inc;
   logic [3:0]         qualified;
   logic               wall_hit;
   logic               ladder_hit;
   logic [7:0]         edge_cnt [4];
   logic               ladder_seen;
   logic               ladder_cap;
   logic [3:0]         hit_code;

   // Sprite-relative offsets; topLeft is signed so sprites may hang off-screen
   assign off_x = $signed({1'b0, pixelX}) - $signed({topLeftX[10], topLeftX});
   assign off_y = $signed({1'b0, pixelY}) - $signed({topLeftY[10], topLeftY});

   assign in_sprite  = (off_x >= 12'sd0) && (off_x < OBJ_W) &&
                       (off_y >= 12'sd0) && (off_y < OBJ_H);
   assign wall_hit   = monkeyDrawingRequest && wallDrawingRequest;
   assign ladder_hit = monkeyDrawingRequest && ladderDrawingRequest;

   // Edge band classification; corners land in two bands
   always_comb begin
      band = 4'b0000;
      if (in_sprite) begin
         band[3] = (off_x < EDGE_S);
         band[2] = (off_y < EDGE_S);
         band[1] = (off_x >= (OBJ_W - EDGE_S));
         band[0] = (off_y >= (OBJ_H - EDGE_S));
      end
   end

   assign edge_inc = wall_hit ? band : 4'b0000;

   generate
      for (genvar n = 0; n < 4; n++) begin : g_edge
         assign qualified[n] = (edge_cnt[n] >= HIT_THR);

         // Saturating per-edge hit counter; a start-of-frame pixel opens the new frame
         always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
               edge_cnt[n] <= 8'd0;
            end else if (startOfFrame) begin
               edge_cnt[n] <= edge_inc[n] ? 8'd1 : 8'd0;
            end else if (edge_inc[n] && (edge_cnt[n] != CNT_MAX)) begin
               edge_cnt[n] <= edge_cnt[n] + 8'd1;
            end
         end
      end
   endgenerate

   // Ladder flag plus frame capture of the edge code and ladder flag
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         ladder_seen <= 1'b0;
         ladder_cap  <= 1'b0;
         hit_code    <= 4'b0000;
      end else if (startOfFrame) begin
         ladder_seen <= ladder_hit;
         ladder_cap  <= ladder_seen;
         hit_code    <= qualified;
      end else if (ladder_hit) begin
         ladder_seen <= 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state <= ACCUM;
      end else begin
         state <= next_state;
      end
   end

   // Next state and report outputs; REPORT lasts one cycle unless re-triggered
   always_comb begin
      next_state      = state;
      wallCollision   = 1'b0;
      ladderCollision = 1'b0;
      if (startOfFrame) begin
         next_state = REPORT;
      end else if (state == REPORT) begin
         next_state = ACCUM;
      end
      if (state == REPORT) begin
         wallCollision   = (hit_code != 4'b0000);
         ladderCollision = ladder_cap;
      end
   end

   assign HitEdgeCode = hit_code;

endmodule
`default_nettype wire

// File: tb/tb_monkey_collision_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_monkey_collision_detect
// Description : Self-checking bench for monkey_collision_detect: directed
//               vector table, hand-written corner sequences, and randomized
//               traffic against a per-frame reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_monkey_collision_detect;

   localparam int OW = 32;
   localparam int OH = 32;
   localparam int EW = 4;
   localparam int HM = 2;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        startOfFrame = 1'b0;
   logic [10:0] pixelX = '0;
   logic [10:0] pixelY = '0;
   logic [10:0] topLeftX = '0;
   logic [10:0] topLeftY = '0;
   logic        monkeyDrawingRequest = 1'b0;
   logic        wallDrawingRequest = 1'b0;
   logic        ladderDrawingRequest = 1'b0;
   logic        wallCollision;
   logic        ladderCollision;
   logic [3:0]  HitEdgeCode;

   monkey_collision_detect #(
      .OBJECT_WIDTH (OW),
      .OBJECT_HEIGHT(OH),
      .EDGE_W       (EW),
      .HIT_MIN      (HM)
   ) dut (
      .clk                 (clk),
      .resetN              (resetN),
      .startOfFrame        (startOfFrame),
      .pixelX              (pixelX),
      .pixelY              (pixelY),
      .topLeftX            (topLeftX),
      .topLeftY            (topLeftY),
      .monkeyDrawingRequest(monkeyDrawingRequest),
      .wallDrawingRequest  (wallDrawingRequest),
      .ladderDrawingRequest(ladderDrawingRequest),
      .wallCollision       (wallCollision),
      .ladderCollision     (ladderCollision),
      .HitEdgeCode         (HitEdgeCode)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Sprite position used by the stimulus, as signed integers
   int tlx = 100;
   int tly = 200;

   // Reference model: hit counts per edge for the open frame, plus last report
   int m_cnt [4];
   bit m_seen;
   bit m_rep;
   bit m_lcap;
   int m_code;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int wrap12(input int v);
      int w;
      w = ((v % 4096) + 4096) % 4096;
      return (w >= 2048) ? w - 4096 : w;
   endfunction

   task automatic model_reset();
      for (int n = 0; n < 4; n++) m_cnt[n] = 0;
      m_seen = 0;
      m_rep  = 0;
      m_lcap = 0;
      m_code = 0;
   endtask

   // One clock of the model: close the frame on SOF, then account this pixel
   task automatic model_clock(input bit sof, input int px, input int py,
                              input bit mon, input bit wall, input bit lad);
      int ox;
      int oy;
      bit [3:0] e;
      if (sof) begin
         m_code = 0;
         for (int n = 0; n < 4; n++) if (m_cnt[n] >= HM) m_code |= (1 << n);
         m_lcap = m_seen;
         m_rep  = 1;
         for (int n = 0; n < 4; n++) m_cnt[n] = 0;
         m_seen = 0;
      end else begin
         m_rep = 0;
      end
      ox = wrap12(px - wrap12(tlx));
      oy = wrap12(py - wrap12(tly));
      e = '0;
      if (ox >= 0 && ox < OW && oy >= 0 && oy < OH) begin
         e[3] = (ox < EW);
         e[2] = (oy < EW);
         e[1] = (ox >= OW - EW);
         e[0] = (oy >= OH - EW);
      end
      if (mon && wall)
         for (int n = 0; n < 4; n++) if (e[n] && m_cnt[n] < 255) m_cnt[n]++;
      if (mon && lad) m_seen = 1;
   endtask

   // Drive one cycle of inputs, clock it, and advance the model
   task automatic step(input bit sof, input int px, input int py,
                       input bit mon, input bit wall, input bit lad);
      startOfFrame         = sof;
      pixelX               = 11'(px);
      pixelY               = 11'(py);
      topLeftX             = 11'(tlx);
      topLeftY             = 11'(tly);
      monkeyDrawingRequest = mon;
      wallDrawingRequest   = wall;
      ladderDrawingRequest = lad;
      @(posedge clk);
      model_clock(sof, px, py, mon, wall, lad);
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, " wall"},   int'(wallCollision),   int'(m_rep && m_code != 0));
      check({tag, " ladder"}, int'(ladderCollision), int'(m_rep && m_lcap));
      check({tag, " code"},   int'(HitEdgeCode),     m_code);
   endtask

   task automatic check_out(input string tag, input int ew, input int el, input int ec);
      check({tag, " wall"},   int'(wallCollision),   ew);
      check({tag, " ladder"}, int'(ladderCollision), el);
      check({tag, " code"},   int'(HitEdgeCode),     ec);
   endtask

   typedef struct {
      bit sof;
      int px;
      int py;
      bit mon;
      bit wall;
      bit lad;
      int ew;
      int el;
      int ec;
   } vec_t;

   localparam int NV = 27;
   vec_t tab [NV];

   initial begin
      // Directed frames, sprite at (100,200)
      tab[0]  = '{1, 0,   0,   0, 0, 0, 0, 0, 0};   // empty frame close
      tab[1]  = '{0, 0,   0,   0, 0, 0, 0, 0, 0};
      tab[2]  = '{0, 110, 230, 1, 1, 0, 0, 0, 0};   // three bottom hits
      tab[3]  = '{0, 111, 230, 1, 1, 0, 0, 0, 0};
      tab[4]  = '{0, 112, 230, 1, 1, 0, 0, 0, 0};
      tab[5]  = '{1, 0,   0,   0, 0, 0, 1, 0, 1};   // bottom reported
      tab[6]  = '{0, 0,   0,   0, 0, 0, 0, 0, 1};
      tab[7]  = '{0, 100, 200, 1, 1, 0, 0, 0, 1};   // single corner hit
      tab[8]  = '{1, 0,   0,   0, 0, 0, 0, 0, 0};   // below threshold
      tab[9]  = '{0, 0,   0,   0, 0, 0, 0, 0, 0};
      tab[10] = '{0, 100, 210, 1, 1, 0, 0, 0, 0};   // two left hits
      tab[11] = '{0, 101, 211, 1, 1, 0, 0, 0, 0};
      tab[12] = '{1, 0,   0,   0, 0, 0, 1, 0, 8};
      tab[13] = '{0, 0,   0,   0, 0, 0, 0, 0, 8};   // pulse gone, code held
      tab[14] = '{0, 0,   0,   0, 0, 0, 0, 0, 8};
      tab[15] = '{0, 115, 215, 1, 0, 1, 0, 0, 8};   // interior ladder
      tab[16] = '{1, 0,   0,   0, 0, 0, 0, 1, 0};
      tab[17] = '{0, 0,   0,   0, 0, 0, 0, 0, 0};
      tab[18] = '{1, 110, 230, 1, 1, 0, 0, 0, 0};   // hit on SOF -> new frame
      tab[19] = '{0, 111, 230, 1, 1, 0, 0, 0, 0};
      tab[20] = '{1, 0,   0,   0, 0, 0, 1, 0, 1};
      tab[21] = '{0, 0,   0,   0, 0, 0, 0, 0, 1};
      tab[22] = '{0, 110, 230, 1, 1, 0, 0, 0, 1};
      tab[23] = '{0, 111, 230, 1, 1, 0, 0, 0, 1};
      tab[24] = '{1, 115, 215, 1, 0, 1, 1, 0, 1};   // SOF with ladder pixel
      tab[25] = '{1, 0,   0,   0, 0, 0, 0, 1, 0};   // back-to-back SOF
      tab[26] = '{0, 0,   0,   0, 0, 0, 0, 0, 0};

      model_reset();

      // Reset state, checked while reset is held
      #3;
      check_out("reset", 0, 0, 0);
      @(posedge clk);
      #1 resetN = 1'b1;

      for (int i = 0; i < NV; i++) begin
         step(tab[i].sof, tab[i].px, tab[i].py, tab[i].mon, tab[i].wall, tab[i].lad);
         check_out($sformatf("vec%0d", i), tab[i].ew, tab[i].el, tab[i].ec);
      end

      // Counter saturation: 256 bottom hits must not wrap below threshold
      for (int i = 0; i < 256; i++) step(0, 110 + (i % 8), 230, 1, 1, 0);
      step(1, 0, 0, 0, 0, 0);
      check_out("saturate", 1, 0, 1);
      step(0, 0, 0, 0, 0, 0);

      // Reset mid-frame discards the interrupted frame
      step(0, 110, 230, 1, 1, 0);
      step(0, 111, 230, 1, 1, 0);
      step(0, 112, 230, 1, 1, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 113, 230, 1, 1, 0);
      step(0, 114, 230, 1, 1, 0);
      step(0, 115, 230, 1, 1, 0);
      #2 resetN = 1'b0;
      model_reset();
      #1;
      check_out("async reset", 0, 0, 0);
      @(posedge clk);
      #1 resetN = 1'b1;
      step(1, 0, 0, 0, 0, 0);
      check_out("post reset", 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      check_out("post reset+1", 0, 0, 0);

      // Randomized frames against the model
      for (int i = 0; i < 3000; i++) begin
         bit sof;
         int px;
         int py;
         sof = ($urandom_range(0, 19) == 0);
         if (sof && $urandom_range(0, 1) == 1) begin
            tlx = int'($urandom_range(0, 120)) - 40;
            tly = int'($urandom_range(0, 120)) - 40;
         end
         px = (tlx + int'($urandom_range(0, OW + 7)) - 4) & 2047;
         py = (tly + int'($urandom_range(0, OH + 7)) - 4) & 2047;
         step(sof, px, py, ($urandom_range(0, 9) < 7), ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 19) == 0));
         check_model($sformatf("rand%0d", i));
         if (i == 1500) begin
            #2 resetN = 1'b0;
            model_reset();
            #1;
            check_out("rand reset", 0, 0, 0);
            @(posedge clk);
            #1 resetN = 1'b1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/monkey_collision_detect.md
MONKEY_COLLISION_DETECT -- requirements
Module: monkey_collision_detect

Interface
REQ-001 SHALL have parameter OBJECT_WIDTH, default 32, meaning monkey sprite width in pixels.
REQ-002 SHALL have parameter OBJECT_HEIGHT, default 32, meaning monkey sprite height in pixels.
REQ-003 SHALL have parameter EDGE_W, default 4, meaning edge band thickness in pixels.
REQ-004 SHALL have parameter HIT_MIN, default 2, meaning per-edge overlap pixel count per frame that qualifies an edge hit.
REQ-005 SHALL have port clk  input  1  system clock; all logic on its rising edge, one clock only.
REQ-006 SHALL have port resetN  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port startOfFrame  input  1  one-cycle pulse at the start of each frame.
REQ-008 SHALL have port pixelX  input  11  current scan X, unsigned.
REQ-009 SHALL have port pixelY  input  11  current scan Y, unsigned.
REQ-010 SHALL have port topLeftX  input  11  monkey top-left X, signed.
REQ-011 SHALL have port topLeftY  input  11  monkey top-left Y, signed.
REQ-012 SHALL have port monkeyDrawingRequest  input  1  monkey opaque pixel at (pixelX,pixelY).
REQ-013 SHALL have port wallDrawingRequest  input  1  wall/floor pixel at (pixelX,pixelY).
REQ-014 SHALL have port ladderDrawingRequest  input  1  ladder pixel at (pixelX,pixelY).
REQ-015 SHALL have port wallCollision  output  1  one-cycle frame-report pulse, qualified wall hit last frame.
REQ-016 SHALL have port ladderCollision  output  1  one-cycle frame-report pulse, ladder overlap last frame.
REQ-017 SHALL have port HitEdgeCode  output  4  edges hit last frame: [3] left, [2] top, [1] right, [0] bottom.

Function
REQ-018 SHALL compute offX = pixelX - topLeftX and offY = pixelY - topLeftY in 12-bit signed arithmetic; band logic applies only when 0 <= offX < OBJECT_WIDTH and 0 <= offY < OBJECT_HEIGHT.
REQ-019 SHALL classify an in-sprite pixel: left if offX < EDGE_W; right if offX >= OBJECT_WIDTH-EDGE_W; top if offY < EDGE_W; bottom if offY >= OBJECT_HEIGHT-EDGE_W; corner pixels count toward both edges; interior pixels count toward none.
REQ-020 SHALL, on a wall hit cycle (monkeyDrawingRequest && wallDrawingRequest), increment each classified edge's 8-bit counter, saturating at 255.
REQ-021 SHALL, on a ladder hit cycle (monkeyDrawingRequest && ladderDrawingRequest), set a ladderSeen flag regardless of edge classification.
REQ-022 SHALL use a two-state FSM: ACCUM (counting) and REPORT; ACCUM -> REPORT on startOfFrame; REPORT -> ACCUM unconditionally after one cycle.
REQ-023 SHALL, on the startOfFrame cycle, capture edge bit n = (counter[n] >= HIT_MIN) into HitEdgeCode and capture ladderSeen, then clear all counters and ladderSeen.
REQ-024 SHALL, in the REPORT cycle (startOfFrame+1), assert wallCollision iff captured HitEdgeCode != 0 and ladderCollision iff captured ladderSeen; both low in every other cycle.
REQ-025 SHALL hold HitEdgeCode stable from REPORT until the next startOfFrame capture.
REQ-026 SHALL, when startOfFrame coincides with a hit pixel, count that pixel toward the new frame (counter = 1 after clear), not the reported frame.
REQ-027 SHALL, when startOfFrame arrives during REPORT, perform a fresh capture and remain in REPORT one more cycle.
REQ-028 SHALL treat a sprite partially off-screen (negative topLeft) with no special case beyond REQ-018.

Reset
REQ-029 SHALL, on resetN low at any time including mid-frame, immediately clear counters, ladderSeen, HitEdgeCode=0, wallCollision=0, ladderCollision=0, FSM=ACCUM.
REQ-030 SHALL suppress any report for the frame interrupted by reset; the first startOfFrame after release reports only hits since release.

Verification
REQ-031 Monkey at (100,200), 3 wall hits at pixelY 230, pixelX 110..112, then SOF -> cycle SOF+1 wallCollision=1, HitEdgeCode=4'b0001.
REQ-032 Single wall hit at (100,200) (corner), then SOF -> wallCollision=0, HitEdgeCode=0 (below HIT_MIN=2).
REQ-033 Two hits at (100,210) and (101,211), then SOF -> HitEdgeCode=4'b1000, pulse exactly one cycle, code held through next frame.
REQ-034 Ladder hit at interior (115,215), no wall, then SOF -> ladderCollision=1, wallCollision=0, HitEdgeCode=0.
REQ-035 Wall hit coinciding with SOF, one more bottom hit next frame, then SOF -> first report 0, second report HitEdgeCode=4'b0001.
REQ-036 Three bottom hits, resetN pulsed low, SOF -> all outputs 0, no pulse.
